// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared definitions for the hazard/forwarding controller: forward-select
// encodings, the shadow pipeline-stage record and the writer predicate.
package hazard_fwd_ctrl_pkg;

    localparam int REG_W = 5;

    // Encodings match the 3-input EX operand data mux.
    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    // Shadow copy of one pipeline stage's destination-register state.
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             regwrite;
        logic             memread;
    } stage_t;

    localparam stage_t STAGE_EMPTY = '{
        valid:    1'b0,
        rd:       {REG_W{1'b0}},
        regwrite: 1'b0,
        memread:  1'b0
    };

    // A stage only counts as a producer if it really writes a non-zero register.
    function automatic logic is_writer(input stage_t s);
        return s.valid & s.regwrite & (s.rd != {REG_W{1'b0}});
    endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_sel_unit.sv
// Priority compare of one ID source register against the EX and MEM shadow
// stages. The newer producer (EX) wins over the older one (MEM); register 0
// and unused sources never forward.
module fwd_sel_unit
    import hazard_fwd_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] src,
    input  logic             src_used,
    input  stage_t           ex_q,
    input  stage_t           mem_q,
    output fwd_sel_e         sel
);

    // Select the youngest in-flight producer of src, else the register file.
    always_comb begin
        sel = FWD_RF;
        if (!src_used || (src == {REG_W{1'b0}})) begin
            sel = FWD_RF;
        end else if (is_writer(ex_q) && (ex_q.rd == src)) begin
            sel = FWD_EXMEM;
        end else if (is_writer(mem_q) && (mem_q.rd == src)) begin
            sel = FWD_MEMWB;
        end else begin
            sel = FWD_RF;
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Pipeline hazard and forwarding controller for the 5-stage core.
// Tracks destination-register state of EX/MEM/WB, produces registered EX
// operand forward selects, and the load-use stall / bubble / flush controls.
module hazard_fwd_ctrl #(
    parameter int REG_W = hazard_fwd_ctrl_pkg::REG_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             mem_busy,
    input  logic             flush,
    output logic             stall_if_id,
    output logic             bubble_ex,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_cnt
);

    import hazard_fwd_ctrl_pkg::*;

    stage_t     ex_r;
    stage_t     mem_r;
    stage_t     wb_r;
    stage_t     id_entry_s;
    fwd_sel_e   sel_a_s;
    fwd_sel_e   sel_b_s;
    fwd_sel_e   fwd_a_r;
    fwd_sel_e   fwd_b_r;
    logic [CNT_W-1:0] stall_cnt_r;
    logic       lu_s;

    assign id_entry_s = '{
        valid:    id_valid,
        rd:       id_rd,
        regwrite: id_regwrite,
        memread:  id_memread
    };

    fwd_sel_unit u_fwd_rs (
        .src      (id_rs),
        .src_used (id_rs_used),
        .ex_q     (ex_r),
        .mem_q    (mem_r),
        .sel      (sel_a_s)
    );

    fwd_sel_unit u_fwd_rt (
        .src      (id_rt),
        .src_used (id_rt_used),
        .ex_q     (ex_r),
        .mem_q    (mem_r),
        .sel      (sel_b_s)
    );

    // Load-use hazard: a load in EX produces a register the ID instruction reads.
    always_comb begin
        lu_s = 1'b0;
        if (id_valid && is_writer(ex_r) && ex_r.memread) begin
            lu_s = (id_rs_used && (id_rs == ex_r.rd)) ||
                   (id_rt_used && (id_rt == ex_r.rd));
        end else begin
            lu_s = 1'b0;
        end
    end

    // Pipeline-register controls, priority mem_busy > flush > load-use > advance.
    always_comb begin
        stall_if_id = 1'b0;
        bubble_ex   = 1'b0;
        if (mem_busy) begin
            stall_if_id = 1'b1;
            bubble_ex   = 1'b0;
        end else if (flush) begin
            stall_if_id = 1'b0;
            bubble_ex   = 1'b1;
        end else if (lu_s) begin
            stall_if_id = 1'b1;
            bubble_ex   = 1'b1;
        end else begin
            stall_if_id = 1'b0;
            bubble_ex   = 1'b0;
        end
    end

    // Shadow shift register, forward-select registers and stall counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_r        <= STAGE_EMPTY;
            mem_r       <= STAGE_EMPTY;
            wb_r        <= STAGE_EMPTY;
            fwd_a_r     <= FWD_RF;
            fwd_b_r     <= FWD_RF;
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (mem_busy) begin
            // Whole pipeline frozen: everything holds.
            ex_r        <= ex_r;
            mem_r       <= mem_r;
            wb_r        <= wb_r;
            fwd_a_r     <= fwd_a_r;
            fwd_b_r     <= fwd_b_r;
            stall_cnt_r <= stall_cnt_r;
        end else if (flush || lu_s) begin
            // A bubble enters EX; older stages keep draining.
            ex_r    <= STAGE_EMPTY;
            mem_r   <= ex_r;
            wb_r    <= mem_r;
            fwd_a_r <= FWD_RF;
            fwd_b_r <= FWD_RF;
            if (!flush && (stall_cnt_r != {CNT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end else begin
            ex_r        <= id_entry_s;
            mem_r       <= ex_r;
            wb_r        <= mem_r;
            fwd_a_r     <= sel_a_s;
            fwd_b_r     <= sel_b_s;
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign fwd_a_sel = fwd_a_r;
    assign fwd_b_sel = fwd_b_r;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: doc/hazard_fwd_ctrl.md
# hazard_fwd_ctrl

Pipeline hazard and forwarding controller for the 5-stage core. Keeps a shadow copy of destination-register state for the EX, MEM and WB stages. From this it produces the registered 2-bit selects that drive the two EX-operand 3-input forwarding muxes, plus the load-use stall, bubble-insertion and branch-flush handling for the IF/ID and ID/EX pipeline registers. Sits beside the ID stage; its outputs go to the PC/IF-ID enables, the ID/EX bubble mux and the EX operand muxes.

## Interface
- REG_W, 5, register-index width
- CNT_W, 16, width of the saturating load-use stall counter
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs, id_rt  in  REG_W  source register indices of the ID instruction
- id_rs_used, id_rt_used  in  1  the corresponding source is actually read
- id_rd  in  REG_W  destination index of the ID instruction
- id_regwrite  in  1  the ID instruction writes id_rd
- id_memread  in  1  the ID instruction is a load
- mem_busy  in  1  data-memory wait; freezes the whole pipeline
- flush  in  1  branch/jump taken, resolved in EX; kills the IF and ID instructions
- stall_if_id  out  1  hold PC and IF/ID (combinational)
- bubble_ex  out  1  load a NOP into ID/EX (combinational)
- fwd_a_sel, fwd_b_sel  out  2  EX operand selects, registered: 0 = register file, 1 = EX/MEM result, 2 = MEM/WB writeback data; 3 is never driven
- stall_cnt  out  CNT_W  number of load-use stall cycles, saturating

## Operation
- Shadow stages ex_q, mem_q and wb_q each hold {valid, rd, regwrite, memread}.
- "Writer" means: valid & regwrite & rd != 0.
- Load-use hazard (lu):
  - id_valid & ex_q is a writer & ex_q.memread
  - and either (id_rs_used & id_rs == ex_q.rd) or (id_rt_used & id_rt == ex_q.rd).
- Priority when several conditions are true: mem_busy > flush > lu > normal advance.
- mem_busy:
  - stall_if_id = 1, bubble_ex = 0.
  - All shadow stages, fwd selects and stall_cnt hold.
- flush (mem_busy low):
  - stall_if_id = 0, bubble_ex = 1.
  - ex_q <= invalid, mem_q <= ex_q, wb_q <= mem_q; fwd selects <= 0.
  - lu is ignored.
- lu (mem_busy and flush low):
  - stall_if_id = 1, bubble_ex = 1.
  - ex_q <= invalid, mem_q <= ex_q, wb_q <= mem_q; fwd selects <= 0.
  - stall_cnt increments, saturating at all-ones.
- Normal advance:
  - stall_if_id = 0, bubble_ex = 0.
  - ex_q <= {id_valid, id_rd, id_regwrite, id_memread}; mem_q <= ex_q; wb_q <= mem_q.
- Forward select for each source, computed in ID and registered on advance:
  - 0 if the source is unused or its index is 0.
  - Else 1 if ex_q is a writer with a matching rd (producer will be in MEM).
  - Else 2 if mem_q is a writer with a matching rd (producer will be in WB).
  - Else 0. wb_q matches need no forwarding: the register file writes in the first half-cycle and reads in the second.
- Dual match: the newer producer (select 1) wins.
- Register 0 never forwards and never stalls.

## Timing
- stall_if_id and bubble_ex are combinational from the ID inputs, shadow state, mem_busy and flush. No cycle of latency.
- fwd selects update on the edge that moves the ID instruction into EX, and are valid throughout that instruction's EX cycle.
- Load-use costs exactly 1 stall cycle:
  - On the next cycle the load sits in mem_q, so the consumer advances with select 2.
- Reset (async assert, sync-safe deassert):
  - ex_q, mem_q and wb_q invalid.
  - fwd_a_sel and fwd_b_sel = 0; stall_cnt = 0.
  - As a consequence, stall_if_id = 0 and bubble_ex = 0 unless mem_busy or flush is asserted.
- Reset mid-stall: all state clears; the pending stall is dropped.
- A flush and lu in the same cycle: flush wins and stall_cnt does not increment.

## Structure
- Shared package/constants file:
  - fwd select encodings FWD_RF = 0, FWD_EXMEM = 1, FWD_MEMWB = 2, matching the 3-input data mux encoding;
  - the shadow-stage record layout;
  - REG_W.
- One sub-module, fwd_sel_unit: combinational priority compare of one source against ex_q and mem_q. Instantiated twice, once for rs and once for rt.
- Shadow shift register, hazard/priority logic and counter are at top level.

## Test plan
- ADD r3 in ID, then next instruction uses rs = r3 → fwd_a_sel = 1 in its EX cycle; no stall.
- LW r5, then ADD using rt = r5 →
  - cycle 1: stall_if_id = 1, bubble_ex = 1, stall_cnt 0 → 1;
  - next cycle: advance with fwd_b_sel = 2.
- Producer writing r0, consumer reads r0 → selects 0, no stall.
- Two back-to-back writers to r7, consumer reads r7 → fwd_a_sel = 1, not 2.
- Load-use with flush in the same cycle → bubble_ex = 1, stall_if_id = 0, stall_cnt unchanged. Repeat with mem_busy high: everything frozen, selects hold.
- Force stall_cnt to all-ones via 2^CNT_W load-use events (CNT_W = 4 build) → it stays at 15. Assert rst_n low mid-stall → all outputs reset immediately.
